// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain driver.
package scan_pkg;

  localparam int SCAN_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_shift_ctr.sv
// Bit counter for the scan shift phase: cleared on accept, advanced once per shift cycle.
module scan_shift_ctr
  import scan_pkg::*;
#(
  parameter int N = SCAN_N_DEFAULT,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/scan_chain_driver.sv
// Parallel-to-serial scan chain driver with optional readback of the previous chain
// contents, enabled by defining SCAN_READBACK_EN.
module scan_chain_driver
  import scan_pkg::*;
#(
  parameter int N = SCAN_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic         scan_d,
  output logic         scan_en,
  input  logic         scan_so,
  output logic [N-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic         done
);

  localparam int CW = $clog2(N) + 1;

  scan_state_t   state;
  logic [N-1:0]  word;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;
  logic          accept;
  logic          shifting;
  logic          nxt_bit;
  logic          done_go;

  assign accept   = (state == IDLE) && wr_valid;
  assign shifting = (state == SHIFT);
  assign cnt_nxt  = cnt + CW'(1);
  // Bit presented in the following shift cycle; only consumed while cnt < N-1.
  assign nxt_bit  = |(word & (N'(1) << cnt_nxt));

  scan_shift_ctr #(.N(N)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (shifting),
    .cnt  (cnt),
    .last (last)
  );

`ifdef SCAN_READBACK_EN
  logic [N-1:0] cap;

  assign done_go = rd_ready;
  assign rd_data = cap;
`else
  logic unused_rb;

  assign done_go   = 1'b1;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
  assign unused_rb = scan_so ^ rd_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      wr_ready <= 1'b1;
      scan_en  <= 1'b0;
      scan_d   <= 1'b0;
      done     <= 1'b0;
`ifdef SCAN_READBACK_EN
      cap      <= '0;
      rd_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SCAN_READBACK_EN
      // The chain's last flop arrives first, so it ends up at bit 0 after N shifts.
      if (scan_en) begin
        cap <= {scan_so, cap[N-1:1]};
      end
`endif
      case (state)
        IDLE: begin
          if (wr_valid) begin
            word     <= wr_data;
            state    <= SHIFT;
            wr_ready <= 1'b0;
            scan_en  <= 1'b1;
            scan_d   <= wr_data[0];
          end
        end
        SHIFT: begin
          if (last) begin
            state   <= DONE;
            scan_en <= 1'b0;
            scan_d  <= 1'b0;
`ifdef SCAN_READBACK_EN
            rd_valid <= 1'b1;
`endif
          end else begin
            scan_d <= nxt_bit;
          end
        end
        DONE: begin
          if (done_go) begin
            state    <= IDLE;
            done     <= 1'b1;
            wr_ready <= 1'b1;
`ifdef SCAN_READBACK_EN
            rd_valid <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed plus randomized bench for scan_chain_driver with a behavioural scan chain model.
module tb_scan_chain_driver;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic         scan_d;
  logic         scan_en;
  logic         scan_so;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic         done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [N-1:0] mdl_chain = '0;
  logic [N-1:0] chain = '0;

`ifdef SCAN_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  scan_chain_driver #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .scan_d   (scan_d),
    .scan_en  (scan_en),
    .scan_so  (scan_so),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical chain: scan_d enters the top flop, bit 0 drives scan_so.
  always @(posedge clk) if (scan_en) chain <= {scan_d, chain[N-1:1]};
  assign scan_so = chain[0];

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; nwait = cycles rd_ready stays low in DONE.
  task automatic xfer(input logic [N-1:0] w, input int nwait, input bit junk, input bit chk_gap);
    int t;
    int acc;
    int jk;
    logic [N-1:0] exp_old;
    logic [N-1:0] sh;
    t = 0;
    while (wr_ready !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    check1("wr_ready_idle", wr_ready, 1'b1);
    exp_old  = mdl_chain;
    jk       = $urandom_range(1, N - 1);
    wr_data  = w;
    wr_valid = 1'b1;
    rd_ready = (nwait == 0);
    step();
    acc      = cyc;
    wr_valid = 1'b0;
    wr_data  = N'($urandom);
    if (chk_gap) checki("accept_gap", acc - last_acc, N + 2);
    last_acc = acc;
    for (int k = 0; k < N; k++) begin
      sh = w >> k;
      check1("scan_en_shift", scan_en, 1'b1);
      check1("scan_d_bit", scan_d, sh[0]);
      check1("wr_ready_shift", wr_ready, 1'b0);
      check1("done_shift", done, 1'b0);
      check1("rd_valid_shift", rd_valid, 1'b0);
      if (junk && k == jk) begin
        wr_valid = 1'b1;
        wr_data  = ~w;
      end else begin
        wr_valid = 1'b0;
      end
      step();
    end
    wr_valid = 1'b0;
    check1("scan_en_off", scan_en, 1'b0);
    checkw("chain_after", chain, w);
    check1("done_pre", done, 1'b0);
    if (RB) begin
      check1("rd_valid_done", rd_valid, 1'b1);
      checkw("rd_data_done", rd_data, exp_old);
      for (int i = 0; i < nwait; i++) begin
        wr_valid = 1'b1;
        wr_data  = ~w;
        step();
        check1("rd_valid_hold", rd_valid, 1'b1);
        checkw("rd_data_hold", rd_data, exp_old);
        check1("wr_ready_hold", wr_ready, 1'b0);
        check1("done_hold", done, 1'b0);
      end
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checki("done_latency", cyc - acc, N + 1 + nwait);
    end else begin
      check1("rd_valid_off", rd_valid, 1'b0);
      checkw("rd_data_off", rd_data, '0);
      step();
      checki("done_latency", cyc - acc, N + 1);
    end
    check1("done_pulse", done, 1'b1);
    check1("wr_ready_back", wr_ready, 1'b1);
    check1("rd_valid_clr", rd_valid, 1'b0);
    mdl_chain = w;
  endtask

  initial begin
    logic [N-1:0] w;
    // Asynchronous reset: asserted between clock edges.
    #1 rst = 1'b1;
    #2;
    check1("rst_wr_ready", wr_ready, 1'b1);
    check1("rst_scan_en", scan_en, 1'b0);
    check1("rst_scan_d", scan_d, 1'b0);
    check1("rst_rd_valid", rd_valid, 1'b0);
    checkw("rst_rd_data", rd_data, '0);
    check1("rst_done", done, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    check1("post_rst_ready", wr_ready, 1'b1);

    xfer(8'hA5, 0, 1'b0, 1'b0);
    xfer(8'h3C, 0, 1'b0, 1'b0);
    xfer(8'hFF, 5, 1'b0, 1'b0);
    step();
    check1("done_one_cycle", done, 1'b0);

    xfer(8'h01, 0, 1'b0, 1'b0);
    xfer(8'h80, 0, 1'b0, 1'b1);

    xfer(8'h5A, 0, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      w = N'($urandom);
      xfer(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Abort a 0xA5 transfer after four shift edges.
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (4) step();
    check1("abort_pre_en", scan_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("abort_scan_en", scan_en, 1'b0);
    check1("abort_rd_valid", rd_valid, 1'b0);
    check1("abort_done", done, 1'b0);
    mdl_chain = (mdl_chain >> 4) | (8'hA5 << 4);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("abort_no_done", done, 1'b0);
    end
    rst = 1'b0;
    step();
    check1("abort_ready", wr_ready, 1'b1);
    check1("abort_no_done_rel", done, 1'b0);
    checkw("abort_chain", chain, mdl_chain);
    xfer(N'($urandom), 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
